// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the write-side requesters, the arbiter and the FIFO write port.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       full;
    logic                       write;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [NREQ-1:0]            grant;
    logic                       busy;

    modport master (
        output req_valid, req_data, full,
        input  req_ready, write, wdata, grant, busy
    );

    modport slave (
        input  req_valid, req_data, full,
        output req_ready, write, wdata, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters with bounded bursts.
// Strobe and data are combinational from the registered grant so the registered full flag gates every beat.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic               WCLK,
    input  logic               WRST,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_last;
    logic [BW-1:0]     r_beat;
    logic              r_busy;

    logic              w_any;
    logic              w_own_valid;
    logic              w_xfer;
    logic              w_burst_end;
    logic [IW-1:0]     w_pick_idle;
    logic [IW-1:0]     w_pick_rel;

    // First valid requester strictly after 'from', wrapping; 'from' itself is searched last.
    function automatic logic [IW-1:0] rr_next(input logic [NREQ-1:0] v, input logic [IW-1:0] from);
        logic [IW-1:0] sel;
        logic [IW-1:0] ci;
        logic          hit;
        int            c;
        sel = from;
        hit = 1'b0;
        for (int j = 1; j <= NREQ; j++) begin
            c  = (int'(from) + j) % NREQ;
            ci = IW'(c);
            if (!hit && v[ci]) begin
                sel = ci;
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return sel;
    endfunction

    function automatic logic [NREQ-1:0] to_onehot(input logic [IW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

    // Per-cycle decode of the handshake and next-owner candidates.
    always_comb begin
        w_any       = |bus.req_valid;
        w_own_valid = bus.req_valid[r_owner];
        w_xfer      = (r_state == S_OWN) && w_own_valid && !bus.full;
        w_burst_end = (r_beat == BW'(BURST_MAX - 1));
        w_pick_idle = rr_next(bus.req_valid, r_last);
        w_pick_rel  = rr_next(bus.req_valid, r_owner);
    end

    assign bus.write     = w_xfer;
    assign bus.wdata     = (r_grant != {NREQ{1'b0}}) ? bus.req_data[r_owner*DATA_WIDTH +: DATA_WIDTH]
                                                     : {DATA_WIDTH{1'b0}};
    assign bus.req_ready = r_grant & {NREQ{!bus.full}};
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;

    // Ownership FSM: full freezes the owner and its beat count; release rotates without a bubble.
    always_ff @(posedge WCLK or posedge WRST) begin
        if (WRST) begin
            r_state <= S_IDLE;
            r_grant <= {NREQ{1'b0}};
            r_owner <= {IW{1'b0}};
            r_last  <= IW'(NREQ - 1);
            r_beat  <= {BW{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_OWN;
                        r_busy  <= 1'b1;
                        r_owner <= w_pick_idle;
                        r_grant <= to_onehot(w_pick_idle);
                        r_beat  <= {BW{1'b0}};
                    end else begin
                        r_grant <= {NREQ{1'b0}};
                        r_busy  <= 1'b0;
                    end
                end
                S_OWN: begin
                    if (bus.full) begin
                        r_beat <= r_beat;
                    end else if (!w_own_valid || w_burst_end) begin
                        r_last <= r_owner;
                        r_beat <= {BW{1'b0}};
                        if (w_any) begin
                            r_owner <= w_pick_rel;
                            r_grant <= to_onehot(w_pick_rel);
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_grant <= {NREQ{1'b0}};
                        end
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= {NREQ{1'b0}};
                    r_busy  <= 1'b0;
                    r_beat  <= {BW{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus a cycle model and per-requester scoreboard.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int BMAX = 4;

    logic WCLK = 1'b0;
    logic WRST = 1'b1;
    always #5 WCLK = ~WCLK;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) bus ();
    fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .BURST_MAX(BMAX)) dut (
        .WCLK (WCLK),
        .WRST (WRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;
    bit sb_en   = 1'b0;

    int m_owner = -1;
    int m_beats = 0;
    int m_last  = NREQ - 1;

    int seq      [NREQ];
    int fifo_seq [NREQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit vbit(input logic [NREQ-1:0] v, input int k);
        return ((v >> k) & 4'b0001) != 4'b0000;
    endfunction

    function automatic int rr_from(input logic [NREQ-1:0] v, input int p);
        for (int j = 1; j <= NREQ; j++) begin
            if (vbit(v, (p + j) % NREQ)) return (p + j) % NREQ;
        end
        return -1;
    endfunction

    // Specification-level model: owner index (-1 idle), beats done in this burst, last owner.
    always @(posedge WCLK or posedge WRST) begin
        bit rel;
        if (WRST) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = NREQ - 1;
        end else if (m_owner < 0) begin
            m_owner = rr_from(bus.req_valid, m_last);
            m_beats = 0;
        end else if (!bus.full) begin
            rel = 1'b1;
            if (vbit(bus.req_valid, m_owner)) begin
                m_beats++;
                rel = (m_beats == BMAX);
            end
            if (rel) begin
                m_last  = m_owner;
                m_owner = rr_from(bus.req_valid, m_owner);
                m_beats = 0;
            end
        end
    end

    // Compare DUT against the model, invariants and the FIFO-side scoreboard on every falling edge.
    always @(negedge WCLK) begin
        logic [3:0]  eg, er;
        logic        ew, eb;
        logic [31:0] tmp;
        logic [7:0]  ed;
        int          id;
        if (run_cmp) begin
            eb  = (m_owner >= 0);
            eg  = eb ? (4'b0001 << m_owner) : 4'b0000;
            ew  = eb && vbit(bus.req_valid, m_owner) && !bus.full;
            tmp = eb ? (bus.req_data >> (8 * m_owner)) : 32'h0;
            ed  = tmp[7:0];
            er  = (eb && !bus.full) ? eg : 4'b0000;
            chk("model grant", 32'(bus.grant), 32'(eg));
            chk("model write", 32'(bus.write), 32'(ew));
            chk("model wdata", 32'(bus.wdata), 32'(ed));
            chk("model req_ready", 32'(bus.req_ready), 32'(er));
            chk("model busy", 32'(bus.busy), 32'(eb));
            chk("inv grant onehot0", 32'($onehot0(bus.grant)), 32'd1);
            chk("inv no write when full", 32'(bus.write & bus.full), 32'd0);
            chk("inv ready onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            if (sb_en && bus.write) begin
                id = 0;
                for (int i = 0; i < NREQ; i++) if (vbit(bus.grant, i)) id = i;
                chk("sb fifo word", 32'(bus.wdata), 32'((id << 6) | (fifo_seq[id] & 63)));
                fifo_seq[id]++;
            end
        end
    end

    task automatic tick();
        @(posedge WCLK);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] g, input logic w, input logic [7:0] d);
        #3;
        chk({nm, " grant"}, 32'(bus.grant), 32'(g));
        chk({nm, " write"}, 32'(bus.write), 32'(w));
        if (w) chk({nm, " wdata"}, 32'(bus.wdata), 32'(d));
    endtask

    task automatic do_reset();
        WRST          = 1'b1;
        bus.req_valid = 4'b0000;
        bus.full      = 1'b0;
        tick();
        WRST = 1'b0;
    endtask

    initial begin
        logic [3:0] acc;
        byte unsigned d2 [4];
        bus.req_valid = 4'b0000;
        bus.req_data  = 32'h0;
        bus.full      = 1'b0;
        tick();
        tick();
        run_cmp = 1'b1;
        chk("reset grant", 32'(bus.grant), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset write", 32'(bus.write), 32'd0);
        chk("reset wdata", 32'(bus.wdata), 32'd0);

        // Single requester: one bubble, then gapless bursts.
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_00A5;
        lit("t1 bubble", 4'b0000, 1'b0, 8'h00); tick();
        for (int i = 0; i < 5; i++) begin
            lit("t1 burst", 4'b0001, 1'b1, 8'hA5); tick();
        end
        bus.req_valid = 4'b0000;
        lit("t1 drop", 4'b0001, 1'b0, 8'h00); tick();
        lit("t1 idle", 4'b0000, 1'b0, 8'h00); tick();

        // All four requesters: rotation every BMAX beats.
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h4332_2110;
        d2 = '{8'h10, 8'h21, 8'h32, 8'h43};
        lit("t2 bubble", 4'b0000, 1'b0, 8'h00); tick();
        for (int i = 0; i < 20; i++) begin
            lit("t2 rotate", 4'b0001 << ((i / 4) % 4), 1'b1, d2[(i / 4) % 4]); tick();
        end

        // Full stall mid-burst keeps owner and beat count.
        do_reset();
        bus.req_valid = 4'b1100;
        bus.req_data  = 32'h6D5C_0000;
        lit("t3 bubble", 4'b0000, 1'b0, 8'h00); tick();
        for (int i = 0; i < 2; i++) begin
            lit("t3 pre", 4'b0100, 1'b1, 8'h5C); tick();
        end
        bus.full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lit("t3 stall", 4'b0100, 1'b0, 8'h00);
            chk("t3 stall ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lit("t3 post", 4'b0100, 1'b1, 8'h5C); tick();
        end
        lit("t3 next", 4'b1000, 1'b1, 8'h6D); tick();

        // Owner drops valid after one beat; grant skips to requester 3 and a full burst follows.
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h3300_110A;
        lit("t4 bubble", 4'b0000, 1'b0, 8'h00); tick();
        lit("t4 beat", 4'b0010, 1'b1, 8'h11); tick();
        bus.req_valid = 4'b1001;
        lit("t4 drop", 4'b0010, 1'b0, 8'h00); tick();
        for (int i = 0; i < 4; i++) begin
            lit("t4 r3", 4'b1000, 1'b1, 8'h33); tick();
        end
        lit("t4 r0", 4'b0001, 1'b1, 8'h0A); tick();

        // Reset mid-burst clears outputs at once; first grant afterwards is requester 0.
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_data  = 32'h7766_5544;
        lit("t5 bubble", 4'b0000, 1'b0, 8'h00); tick();
        lit("t5 own", 4'b1000, 1'b1, 8'h77); tick();
        lit("t5 own2", 4'b1000, 1'b1, 8'h77);
        WRST = 1'b1;
        #1;
        chk("t5 rst grant", 32'(bus.grant), 32'd0);
        chk("t5 rst write", 32'(bus.write), 32'd0);
        chk("t5 rst busy", 32'(bus.busy), 32'd0);
        tick();
        WRST = 1'b0;
        bus.req_valid = 4'b1111;
        lit("t5 bubble2", 4'b0000, 1'b0, 8'h00); tick();
        lit("t5 first", 4'b0001, 1'b1, 8'h44); tick();

        // Random valid/full traffic with per-requester sequence-numbered words.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            seq[i]      = 0;
            fifo_seq[i] = 0;
        end
        sb_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i]       = ($urandom_range(0, 9) < 6);
                bus.req_data[i*8 +: 8] = 8'((i << 6) | (seq[i] & 63));
            end
            bus.full = ($urandom_range(0, 3) == 0);
            #3;
            acc = bus.req_ready & bus.req_valid;
            tick();
            for (int i = 0; i < NREQ; i++) if (acc[i]) seq[i]++;
        end
        bus.req_valid = 4'b0000;
        tick();
        sb_en = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            chk("sb count", 32'(fifo_seq[i]), 32'(seq[i]));
        end
        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
